// File: rtl/vector_seq_engine.sv
// Vector-display sequencer: walks a display list in a 1-cycle sync ROM and drives X/Y DAC codes.
// Define VEC_LOOP_EN to restart the list automatically after each frame until stop.
module vector_seq_engine #(
  parameter int ADDRESSWIDTH = 8,
  parameter int OUT_WIDTH    = 8,
  parameter int DATAWIDTH    = 2*OUT_WIDTH+2,
  parameter int STEP         = 1,
  parameter int FRAMECNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic [DATAWIDTH-1:0]    rom_data,
  output logic [ADDRESSWIDTH-1:0] rom_addr,
  output logic                    rom_rd,
  output logic [OUT_WIDTH-1:0]    xch,
  output logic [OUT_WIDTH-1:0]    ych,
  output logic                    beam_on,
  output logic                    go_flag,
  output logic                    halt_flag,
  output logic                    busy,
  output logic [FRAMECNT_W-1:0]   frame_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LATCH, S_DRAW, S_NEXT, S_END} state_t;

  localparam logic [ADDRESSWIDTH-1:0] ADDR_LAST = '1;
  localparam logic [OUT_WIDTH-1:0]    STEP_C    = OUT_WIDTH'(STEP);

  state_t                  state_q, state_d;
  logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
  logic [OUT_WIDTH-1:0]    x_q, x_d, y_q, y_d, tx_q, tx_d, ty_q, ty_d;
  logic [FRAMECNT_W-1:0]   frame_q, frame_d;
  logic                    rd_q, rd_d, beam_q, beam_d, go_q, go_d, halt_q, halt_d, busy_q, busy_d;

  logic                    w_halt, w_blank;
  logic [OUT_WIDTH-1:0]    w_x, w_y;

  assign w_halt  = rom_data[DATAWIDTH-1];
  assign w_blank = rom_data[DATAWIDTH-2];
  assign w_x     = rom_data[2*OUT_WIDTH-1:OUT_WIDTH];
  assign w_y     = rom_data[OUT_WIDTH-1:0];

  // Moves c toward t by at most STEP_C, landing exactly on t when closer than that.
  function automatic logic [OUT_WIDTH-1:0] step_toward(input logic [OUT_WIDTH-1:0] c,
                                                       input logic [OUT_WIDTH-1:0] t);
    if (c < t) return ((t - c) > STEP_C) ? c + STEP_C : t;
    else       return ((c - t) > STEP_C) ? c - STEP_C : t;
  endfunction

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    addr_d  = addr_q;
    x_d     = x_q;
    y_d     = y_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    frame_d = frame_q;
    go_d    = 1'b0;
    halt_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          addr_d  = '0;
          go_d    = 1'b1;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        if (w_halt) begin
          state_d = S_END;
          halt_d  = 1'b1;
          frame_d = frame_q + FRAMECNT_W'(1);
        end else if (w_blank) begin
          state_d = S_NEXT;
          x_d     = w_x;
          y_d     = w_y;
        end else begin
          state_d = S_DRAW;
          tx_d    = w_x;
          ty_d    = w_y;
        end
      end
      S_DRAW: begin
        x_d = step_toward(x_q, tx_q);
        y_d = step_toward(y_q, ty_q);
        if (x_d == tx_q && y_d == ty_q) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (addr_q == ADDR_LAST) begin
          state_d = S_END;
          halt_d  = 1'b1;
          frame_d = frame_q + FRAMECNT_W'(1);
        end else begin
          state_d = S_FETCH;
          addr_d  = addr_q + ADDRESSWIDTH'(1);
        end
      end
      S_END: begin
        addr_d = '0;
`ifdef VEC_LOOP_EN
        state_d = S_FETCH;
        go_d    = 1'b1;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // Abort beats everything, including a simultaneous start in IDLE; DAC codes hold.
    if (stop) begin
      state_d = S_IDLE;
      addr_d  = '0;
      x_d     = x_q;
      y_d     = y_q;
      frame_d = frame_q;
      go_d    = 1'b0;
      halt_d  = 1'b0;
    end

    rd_d   = (state_d == S_FETCH);
    beam_d = (state_d == S_DRAW);
    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      tx_q    <= '0;
      ty_q    <= '0;
      frame_q <= '0;
      rd_q    <= 1'b0;
      beam_q  <= 1'b0;
      go_q    <= 1'b0;
      halt_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      frame_q <= frame_d;
      rd_q    <= rd_d;
      beam_q  <= beam_d;
      go_q    <= go_d;
      halt_q  <= halt_d;
      busy_q  <= busy_d;
    end
  end

  assign rom_addr  = addr_q;
  assign rom_rd    = rd_q;
  assign xch       = x_q;
  assign ych       = y_q;
  assign beam_on   = beam_q;
  assign go_flag   = go_q;
  assign halt_flag = halt_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_vector_seq_engine.sv
// Bench for vector_seq_engine: two instances (STEP=1 and STEP=3) with 16-entry lists, checked
// cycle by cycle against an expected trace built from the display-list rules.
module tb_vector_seq_engine;

  localparam int AW   = 4;
  localparam int OW   = 8;
  localparam int DW   = 2*OW+2;
  localparam int FW   = 8;
  localparam int LAST = (1 << AW) - 1;

  typedef struct packed {
    logic          busy;
    logic          rd;
    logic [AW-1:0] addr;
    logic [OW-1:0] x;
    logic [OW-1:0] y;
    logic          beam;
    logic          go;
    logic          halt;
  } rec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start     [2];
  logic          stop      [2];
  logic [DW-1:0] rom_data  [2];
  logic [AW-1:0] rom_addr  [2];
  logic          rom_rd    [2];
  logic [OW-1:0] xch       [2];
  logic [OW-1:0] ych       [2];
  logic          beam_on   [2];
  logic          go_flag   [2];
  logic          halt_flag [2];
  logic          busy      [2];
  logic [FW-1:0] frame_cnt [2];

  logic [DW-1:0] mem [2][1 << AW];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    vector_seq_engine #(
      .ADDRESSWIDTH(AW), .OUT_WIDTH(OW), .DATAWIDTH(DW),
      .STEP((g == 0) ? 1 : 3), .FRAMECNT_W(FW)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start[g]), .stop(stop[g]),
      .rom_data(rom_data[g]), .rom_addr(rom_addr[g]), .rom_rd(rom_rd[g]),
      .xch(xch[g]), .ych(ych[g]), .beam_on(beam_on[g]), .go_flag(go_flag[g]),
      .halt_flag(halt_flag[g]), .busy(busy[g]), .frame_cnt(frame_cnt[g])
    );

    always @(posedge clk) if (rom_rd[g]) rom_data[g] <= mem[g][rom_addr[g]];
  end

  int   errors = 0;
  int   checks = 0;
  int   cur_x [2];
  int   cur_y [2];
  int   fc    [2];
  rec_t exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic rec_t mk(input int b, input int rd, input int a, input int x, input int y,
                              input int beam, input int go, input int halt);
    rec_t r;
    r.busy = b[0];  r.rd = rd[0];  r.addr = a[AW-1:0];
    r.x = x[OW-1:0];  r.y = y[OW-1:0];
    r.beam = beam[0];  r.go = go[0];  r.halt = halt[0];
    return r;
  endfunction

  function automatic rec_t sample(input int d);
    rec_t r;
    r.busy = busy[d];  r.rd = rom_rd[d];  r.addr = rom_addr[d];
    r.x = xch[d];  r.y = ych[d];
    r.beam = beam_on[d];  r.go = go_flag[d];  r.halt = halt_flag[d];
    return r;
  endfunction

  function automatic logic [DW-1:0] wd(input int h, input int b, input int x, input int y);
    return {h[0], b[0], x[OW-1:0], y[OW-1:0]};
  endfunction

  function automatic int move(input int c, input int t, input int s);
    if (t > c) return c + (((t - c) < s) ? (t - c) : s);
    else       return c - (((c - t) < s) ? (c - t) : s);
  endfunction

  // Expected per-cycle outputs for nf consecutive frames starting at the current beam position.
  task automatic build(input int d, input int nf);
    int x, y, a, tx, ty, s;
    logic [DW-1:0] w;
    x = cur_x[d];  y = cur_y[d];  s = (d == 0) ? 1 : 3;
    exp_q.delete();
    for (int f = 0; f < nf; f++) begin
      a = 0;
      forever begin
        exp_q.push_back(mk(1, 1, a, x, y, 0, (a == 0) ? 1 : 0, 0));
        exp_q.push_back(mk(1, 0, a, x, y, 0, 0, 0));
        w = mem[d][a];
        if (w[DW-1]) break;
        if (w[DW-2]) begin
          x = int'(w[2*OW-1:OW]);  y = int'(w[OW-1:0]);
        end else begin
          tx = int'(w[2*OW-1:OW]);  ty = int'(w[OW-1:0]);
          do begin
            exp_q.push_back(mk(1, 0, a, x, y, 1, 0, 0));
            x = move(x, tx, s);  y = move(y, ty, s);
          end while (x != tx || y != ty);
        end
        exp_q.push_back(mk(1, 0, a, x, y, 0, 0, 0));
        if (a == LAST) break;
        a++;
      end
      exp_q.push_back(mk(1, 0, a, x, y, 0, 0, 1));
    end
    exp_q.push_back(mk(0, 0, 0, x, y, 0, 0, 0));
  endtask

  // Starts a frame and compares every cycle; stop_idx >= 0 aborts after that trace entry.
  task automatic run(input int d, input string tag, input int stop_idx, input int poke_idx);
    rec_t r;
    int   si;
    si = stop_idx;
`ifdef VEC_LOOP_EN
    if (si < 0) si = exp_q.size() - 2;
`endif
    if (si >= 0) begin
      r = exp_q[si];
      while (exp_q.size() > si + 1) void'(exp_q.pop_back());
      exp_q.push_back(mk(0, 0, 0, int'(r.x), int'(r.y), 0, 0, 0));
    end
    foreach (exp_q[i]) if (exp_q[i].halt) fc[d] = (fc[d] + 1) % (1 << FW);
    cur_x[d] = int'(exp_q[exp_q.size()-1].x);
    cur_y[d] = int'(exp_q[exp_q.size()-1].y);
    @(negedge clk);
    start[d] = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      start[d] = (i == poke_idx);
      stop[d]  = 1'b0;
      check($sformatf("%s cyc%0d", tag, i), 64'(sample(d)), 64'(exp_q[i]));
      if (i == si) stop[d] = 1'b1;
    end
    @(negedge clk);
    stop[d] = 1'b0;
    check({tag, " frame_cnt"}, 64'(frame_cnt[d]), 64'(fc[d]));
  endtask

  task automatic gen(input int d, input bit full);
    int hpos, x, y;
    hpos = $urandom_range(1, 8);
    for (int i = 0; i <= LAST; i++) begin
      x = $urandom_range(0, 255);  y = $urandom_range(0, 255);
      if (i > 0 && $urandom_range(0, 4) == 0) begin
        x = int'(mem[d][i-1][2*OW-1:OW]);  y = int'(mem[d][i-1][OW-1:0]);
      end
      mem[d][i] = wd((!full && i == hpos) ? 1 : 0, ($urandom_range(0, 2) == 0) ? 1 : 0, x, y);
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0;  stop[d] = 1'b0;
      cur_x[d] = 0;  cur_y[d] = 0;  fc[d] = 0;
      for (int i = 0; i <= LAST; i++) mem[d][i] = '0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset with no start.
    repeat (100) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check("reset idle", 64'(sample(d)), 64'(mk(0, 0, 0, 0, 0, 0, 0, 0)));
        check("reset frame_cnt", 64'(frame_cnt[d]), 64'd0);
      end
    end

    // blank(10,10), draw(14,10), halt at STEP=1; a stray start mid-frame is ignored.
    mem[0][0] = wd(0, 1, 10, 10);  mem[0][1] = wd(0, 0, 14, 10);  mem[0][2] = wd(1, 0, 0, 0);
    build(0, 1);
    run(0, "list1", -1, 5);
    check("list1 end x", 64'(xch[0]), 64'd14);

    // STEP=3 draw (0,0)->(7,2).
    mem[1][0] = wd(0, 1, 0, 0);  mem[1][1] = wd(0, 0, 7, 2);  mem[1][2] = wd(1, 1, 99, 99);
    build(1, 1);
    run(1, "step3", -1, -1);

    // Whole ROM with no halt word: implicit end after the last entry.
    for (int d = 0; d < 2; d++) begin
      gen(d, 1'b1);
      build(d, 1);
      run(d, $sformatf("fullrom%0d", d), -1, -1);
    end

    // Random lists terminated by a halt word.
    for (int k = 0; k < 4; k++) begin
      for (int d = 0; d < 2; d++) begin
        gen(d, 1'b0);
        build(d, 1);
        run(d, $sformatf("rand%0d_%0d", d, k), -1, -1);
      end
    end

    // Abort mid-draw: no halt pulse, frame_cnt and beam position held.
    mem[0][0] = wd(0, 1, 0, 0);  mem[0][1] = wd(0, 0, 200, 120);  mem[0][2] = wd(1, 0, 0, 0);
    build(0, 1);
    n = 0;
    while (!exp_q[n].beam) n++;
    run(0, "stopdraw", n + 10, -1);

    // start and stop together in IDLE: stop wins, start not remembered.
    @(negedge clk);
    start[0] = 1'b1;  stop[0] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      start[0] = 1'b0;  stop[0] = 1'b0;
      check("start+stop idle", 64'(sample(0)), 64'(mk(0, 0, 0, cur_x[0], cur_y[0], 0, 0, 0)));
    end
    check("start+stop frame_cnt", 64'(frame_cnt[0]), 64'(fc[0]));

    // Reset asserted mid-frame returns every output to zero at once.
    @(negedge clk);
    start[0] = 1'b1;
    repeat (6) @(negedge clk);
    start[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("midreset outs", 64'(sample(d)), 64'(mk(0, 0, 0, 0, 0, 0, 0, 0)));
      check("midreset frame_cnt", 64'(frame_cnt[d]), 64'd0);
      cur_x[d] = 0;  cur_y[d] = 0;  fc[d] = 0;
    end
    @(negedge clk);
    rst_n = 1'b1;

`ifdef VEC_LOOP_EN
    // Auto-loop: four frames back to back, then abort during the fourth END.
    mem[0][0] = wd(0, 1, 5, 5);  mem[0][1] = wd(0, 0, 9, 7);  mem[0][2] = wd(1, 0, 0, 0);
    build(0, 4);
    run(0, "loop4", -1, -1);
    check("loop4 frame_cnt", 64'(frame_cnt[0]), 64'd4);
    check("loop4 busy", 64'(busy[0]), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
